cv32e40s_xif_id_tracker: RTL and testbench

Tracks the lifecycle of every instruction offloaded over the eXtension interface, from issue through commit to result, using a parametrised number of simultaneously outstanding IDs. It allocates the next free offload ID for the issue stage. It also gives the controller the status it needs for fence, debug entry and interrupt decisions: outstanding count, idle, and writeback pending. It sits in the core next to the ID/EX offload logic and observes the XIF issue, commit and result handshakes.

---
 rtl/cv32e40s_pkg.sv | 10 +
 rtl/cv32e40s_ff_one.sv | 20 ++
 rtl/cv32e40s_xif_id_tracker.sv | 163 ++++++++++++++++
 tb/tb_cv32e40s_xif_id_tracker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the XIF offload ID tracker.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    XID_FREE      = 2'd0,
    XID_ISSUED    = 2'd1,
    XID_COMMITTED = 2'd2
  } xif_id_state_e;

endpackage

// File: rtl/cv32e40s_ff_one.sv
// Priority encoder: index of the lowest set bit, plus an all-zero flag.
module cv32e40s_ff_one #(
  parameter int LEN   = 16,
  parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic [LEN-1:0]   in_i,
  output logic [IDX_W-1:0] first_one_o,
  output logic             no_ones_o
);

  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IDX_W'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40s_xif_id_tracker.sv
// Tracks each XIF offload ID from issue through commit to result, allocates the
// lowest free ID and reports outstanding/idle/writeback status plus a sticky error.
//
// Per-entry state:
//   state          | meaning
//   XID_FREE       | ID unused, may be allocated
//   XID_ISSUED     | accepted by the coprocessor, awaiting commit or kill
//   XID_COMMITTED  | committed, awaiting its result
module cv32e40s_xif_id_tracker
  import cv32e40s_pkg::*;
#(
  parameter int X_ID_WIDTH        = 4,
  parameter int X_MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH         = $clog2(X_MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic                  issue_ready_i,
  input  logic                  issue_accept_i,
  input  logic                  issue_writeback_i,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  output logic                  issue_allowed_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  result_valid_i,
  input  logic                  result_ready_i,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  output logic [CNT_WIDTH-1:0]  outstanding_cnt_o,
  output logic                  all_idle_o,
  output logic                  wb_pending_o,
  output logic                  protocol_err_o,
  output logic [X_ID_WIDTH-1:0] err_id_o
);

  localparam int NUM_IDS = 2 ** X_ID_WIDTH;

  if (X_MAX_OUTSTANDING < 1 || X_MAX_OUTSTANDING > NUM_IDS) begin : g_param_check
    $error("X_MAX_OUTSTANDING must be in 1..2**X_ID_WIDTH");
  end

  xif_id_state_e           w_state [NUM_IDS];
  logic [NUM_IDS-1:0]      w_free_mask;
  logic [NUM_IDS-1:0]      w_wb_pend;
  logic [X_ID_WIDTH-1:0]   w_free_idx;
  logic                    w_no_free;

  logic                    w_issue_hs;
  logic                    w_alloc;
  logic                    w_commit_ok;
  logic                    w_kill;
  logic                    w_result_hs;
  logic                    w_result_ok;
  logic                    w_issue_err;
  logic                    w_commit_err;
  logic                    w_result_err;
  logic                    w_err_any;
  logic [X_ID_WIDTH-1:0]   w_err_id;

  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_err;
  logic [X_ID_WIDTH-1:0]   r_err_id;

  cv32e40s_ff_one #(
    .LEN   (NUM_IDS),
    .IDX_W (X_ID_WIDTH)
  ) u_ff_one (
    .in_i        (w_free_mask),
    .first_one_o (w_free_idx),
    .no_ones_o   (w_no_free)
  );

  assign issue_allowed_o = ~w_no_free & (r_cnt < CNT_WIDTH'(X_MAX_OUTSTANDING));
  // Nothing may be allocated while blocked, so drive ID 0 rather than a stray free index.
  assign issue_id_o      = issue_allowed_o ? w_free_idx : '0;

  assign w_issue_hs  = issue_valid_i & issue_ready_i & issue_accept_i;
  assign w_alloc     = w_issue_hs & issue_allowed_o;
  assign w_commit_ok = commit_valid_i & (w_state[commit_id_i] == XID_ISSUED);
  assign w_kill      = w_commit_ok & commit_kill_i;
  assign w_result_hs = result_valid_i & result_ready_i;
  assign w_result_ok = w_result_hs & (w_state[result_id_i] == XID_COMMITTED);

  assign w_issue_err  = w_issue_hs & ~issue_allowed_o;
  assign w_commit_err = commit_valid_i & ~w_commit_ok;
  assign w_result_err = w_result_hs & ~w_result_ok;

  for (genvar g = 0; g < NUM_IDS; g++) begin : g_entry
    xif_id_state_e r_state;
    xif_id_state_e w_state_nxt;
    logic          r_wb;
    logic          w_wb_nxt;
    logic          w_sel_issue;
    logic          w_sel_commit;
    logic          w_sel_result;

    assign w_sel_issue  = w_alloc     & (issue_id_o  == X_ID_WIDTH'(g));
    assign w_sel_commit = w_commit_ok & (commit_id_i == X_ID_WIDTH'(g));
    assign w_sel_result = w_result_ok & (result_id_i == X_ID_WIDTH'(g));

    // The three selects target disjoint current states, so at most one fires.
    always_comb begin
      w_state_nxt = r_state;
      w_wb_nxt    = r_wb;
      if (w_sel_issue) begin
        w_state_nxt = XID_ISSUED;
        w_wb_nxt    = issue_writeback_i;
      end
      if (w_sel_commit) begin
        w_state_nxt = commit_kill_i ? XID_FREE : XID_COMMITTED;
        if (commit_kill_i) w_wb_nxt = 1'b0;
      end
      if (w_sel_result) begin
        w_state_nxt = XID_FREE;
        w_wb_nxt    = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= XID_FREE;
        r_wb    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_wb    <= w_wb_nxt;
      end
    end

    assign w_state[g]     = r_state;
    assign w_free_mask[g] = (r_state == XID_FREE);
    assign w_wb_pend[g]   = (r_state == XID_COMMITTED) & r_wb;
  end

  always_comb begin
    w_err_any = w_issue_err | w_commit_err | w_result_err;
    w_err_id  = '0;
    if (w_issue_err)       w_err_id = issue_id_o;
    else if (w_commit_err) w_err_id = commit_id_i;
    else if (w_result_err) w_err_id = result_id_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_WIDTH'(w_alloc) - CNT_WIDTH'(w_kill) - CNT_WIDTH'(w_result_ok);
      if (!r_err && w_err_any) begin
        r_err    <= 1'b1;
        r_err_id <= w_err_id;
      end
    end
  end

  assign outstanding_cnt_o = r_cnt;
  assign all_idle_o        = (r_cnt == '0);
  assign wb_pending_o      = |w_wb_pend;
  assign protocol_err_o    = r_err;
  assign err_id_o          = r_err_id;

endmodule

// File: tb/tb_cv32e40s_xif_id_tracker.sv
// Directed and randomized checks of the XIF ID tracker against a per-ID lifecycle model.
module tb_cv32e40s_xif_id_tracker;

  localparam int W    = 4;
  localparam int MAXO = 4;
  localparam int N    = 16;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid_i = 1'b0, issue_ready_i = 1'b0;
  logic          issue_accept_i = 1'b0, issue_writeback_i = 1'b0;
  logic [W-1:0]  issue_id_o;
  logic          issue_allowed_o;
  logic          commit_valid_i = 1'b0, commit_kill_i = 1'b0;
  logic [W-1:0]  commit_id_i = '0;
  logic          result_valid_i = 1'b0, result_ready_i = 1'b0;
  logic [W-1:0]  result_id_i = '0;
  logic [CW-1:0] outstanding_cnt_o;
  logic          all_idle_o, wb_pending_o, protocol_err_o;
  logic [W-1:0]  err_id_o;

  cv32e40s_xif_id_tracker #(.X_ID_WIDTH(W), .X_MAX_OUTSTANDING(MAXO)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_i     (issue_ready_i),
    .issue_accept_i    (issue_accept_i),
    .issue_writeback_i (issue_writeback_i),
    .issue_id_o        (issue_id_o),
    .issue_allowed_o   (issue_allowed_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_i    (result_valid_i),
    .result_ready_i    (result_ready_i),
    .result_id_i       (result_id_i),
    .outstanding_cnt_o (outstanding_cnt_o),
    .all_idle_o        (all_idle_o),
    .wb_pending_o      (wb_pending_o),
    .protocol_err_o    (protocol_err_o),
    .err_id_o          (err_id_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = free, 1 = issued, 2 = committed
  int m_state [N];
  bit m_wb    [N];
  bit m_err;
  int m_err_id;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_state[i] != 0) c++;
    return c;
  endfunction

  function automatic bit m_allowed();
    bit any_free = 1'b0;
    for (int i = 0; i < N; i++) if (m_state[i] == 0) any_free = 1'b1;
    return any_free && (m_cnt() < MAXO);
  endfunction

  function automatic int m_issue_id();
    if (!m_allowed()) return 0;
    for (int i = 0; i < N; i++) if (m_state[i] == 0) return i;
    return 0;
  endfunction

  function automatic bit m_wbp();
    for (int i = 0; i < N; i++) if (m_state[i] == 2 && m_wb[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit iv, input bit ir, input bit acc,
                            input bit wb, input bit cv, input int cid, input bit ck,
                            input bit rv, input bit rr, input int rid);
    int old [N];
    bit e   = 1'b0;
    int eid = 0;
    int iid = m_issue_id();
    bit al  = m_allowed();
    if (r) begin
      for (int i = 0; i < N; i++) begin m_state[i] = 0; m_wb[i] = 1'b0; end
      m_err = 1'b0; m_err_id = 0;
      return;
    end
    old = m_state;
    if (iv && ir && acc) begin
      if (al) begin m_state[iid] = 1; m_wb[iid] = wb; end
      else begin e = 1'b1; eid = iid; end
    end
    if (cv) begin
      if (old[cid] == 1) begin
        m_state[cid] = ck ? 0 : 2;
        if (ck) m_wb[cid] = 1'b0;
      end else if (!e) begin e = 1'b1; eid = cid; end
    end
    if (rv && rr) begin
      if (old[rid] == 2) begin m_state[rid] = 0; m_wb[rid] = 1'b0; end
      else if (!e) begin e = 1'b1; eid = rid; end
    end
    if (e && !m_err) begin m_err = 1'b1; m_err_id = eid; end
  endtask

  task automatic step(input bit iv, input bit ir, input bit acc, input bit wb,
                      input bit cv, input int cid, input bit ck,
                      input bit rv, input bit rr, input int rid);
    issue_valid_i = iv; issue_ready_i = ir; issue_accept_i = acc; issue_writeback_i = wb;
    commit_valid_i = cv; commit_id_i = W'(cid); commit_kill_i = ck;
    result_valid_i = rv; result_ready_i = rr; result_id_i = W'(rid);
    model_step(1'b0, iv, ir, acc, wb, cv, cid, ck, rv, rr, rid);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; result_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; result_valid_i = 1'b0;
    model_step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic iss(input bit wb);      step(1, 1, 1, wb, 0, 0, 0, 0, 0, 0);  endtask
  task automatic cmt(input int id, input bit k); step(0, 0, 0, 0, 1, id, k, 0, 0, 0); endtask
  task automatic res(input int id);      step(0, 0, 0, 0, 0, 0, 0, 1, 1, id); endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (outstanding_cnt_o !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", outstanding_cnt_o); end
    n_vec++; if (issue_id_o !== 4'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", issue_id_o); end
    n_vec++; if (issue_allowed_o !== 1'b1 || all_idle_o !== 1'b1) begin n_err++; $display("FAIL reset_allowed_idle: got %b%b want 11", issue_allowed_o, all_idle_o); end
    n_vec++; if (wb_pending_o !== 1'b0 || protocol_err_o !== 1'b0 || err_id_o !== 4'd0) begin n_err++; $display("FAIL reset_err_wb: got wb=%b err=%b id=%0d want 0 0 0", wb_pending_o, protocol_err_o, err_id_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (issue_id_o !== W'(i)) begin n_err++; $display("FAIL fill_id%0d: got %0d want %0d", i, issue_id_o, i); end
      iss(1'b0);
    end
    n_vec++; if (outstanding_cnt_o !== 3'd4 || issue_allowed_o !== 1'b0) begin n_err++; $display("FAIL fill_full: got cnt=%0d allowed=%b want 4 0", outstanding_cnt_o, issue_allowed_o); end
    n_vec++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL fill_noerr: got %b want 0", protocol_err_o); end
    iss(1'b0);
    n_vec++; if (protocol_err_o !== 1'b1 || err_id_o !== 4'd0) begin n_err++; $display("FAIL fill_overflow_err: got err=%b id=%0d want 1 0", protocol_err_o, err_id_o); end
    n_vec++; if (outstanding_cnt_o !== 3'd4) begin n_err++; $display("FAIL fill_overflow_cnt: got %0d want 4", outstanding_cnt_o); end
  endtask

  task automatic test_writeback();
    do_reset();
    iss(1'b1);
    n_vec++; if (outstanding_cnt_o !== 3'd1 || wb_pending_o !== 1'b0) begin n_err++; $display("FAIL wb_issue: got cnt=%0d wbp=%b want 1 0", outstanding_cnt_o, wb_pending_o); end
    cmt(0, 1'b0);
    n_vec++; if (wb_pending_o !== 1'b1) begin n_err++; $display("FAIL wb_commit: got %b want 1", wb_pending_o); end
    res(0);
    n_vec++; if (wb_pending_o !== 1'b0 || outstanding_cnt_o !== 3'd0 || all_idle_o !== 1'b1) begin n_err++; $display("FAIL wb_result: got wbp=%b cnt=%0d idle=%b want 0 0 1", wb_pending_o, outstanding_cnt_o, all_idle_o); end
    n_vec++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL wb_noerr: got %b want 0", protocol_err_o); end
  endtask

  task automatic test_kill();
    do_reset();
    iss(1'b1);
    iss(1'b1);
    cmt(1, 1'b1);
    n_vec++; if (issue_id_o !== 4'd1 || outstanding_cnt_o !== 3'd1) begin n_err++; $display("FAIL kill_free: got id=%0d cnt=%0d want 1 1", issue_id_o, outstanding_cnt_o); end
    n_vec++; if (protocol_err_o !== 1'b0 || wb_pending_o !== 1'b0) begin n_err++; $display("FAIL kill_noerr: got err=%b wbp=%b want 0 0", protocol_err_o, wb_pending_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) iss(1'b0);
    cmt(1, 1'b0);
    cmt(2, 1'b1);
    n_vec++; if (outstanding_cnt_o !== 3'd3 || issue_id_o !== 4'd2) begin n_err++; $display("FAIL sim_setup: got cnt=%0d id=%0d want 3 2", outstanding_cnt_o, issue_id_o); end
    step(1, 1, 1, 0, 1, 0, 1, 1, 1, 1);
    n_vec++; if (outstanding_cnt_o !== 3'd2 || issue_id_o !== 4'd0) begin n_err++; $display("FAIL sim_three_events: got cnt=%0d id=%0d want 2 0", outstanding_cnt_o, issue_id_o); end
    n_vec++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL sim_noerr: got %b want 0", protocol_err_o); end
  endtask

  task automatic test_early_result();
    do_reset();
    for (int i = 0; i < 3; i++) iss(1'b0);
    iss(1'b1);
    res(3);
    n_vec++; if (protocol_err_o !== 1'b1 || err_id_o !== 4'd3 || outstanding_cnt_o !== 3'd4) begin n_err++; $display("FAIL early_res_err: got err=%b id=%0d cnt=%0d want 1 3 4", protocol_err_o, err_id_o, outstanding_cnt_o); end
    cmt(3, 1'b0);
    n_vec++; if (wb_pending_o !== 1'b1 || err_id_o !== 4'd3) begin n_err++; $display("FAIL early_res_commit: got wbp=%b id=%0d want 1 3", wb_pending_o, err_id_o); end
    res(3);
    n_vec++; if (outstanding_cnt_o !== 3'd3 || wb_pending_o !== 1'b0) begin n_err++; $display("FAIL early_res_final: got cnt=%0d wbp=%b want 3 0", outstanding_cnt_o, wb_pending_o); end
    // commit error outranks result error in the same cycle
    do_reset();
    step(0, 0, 0, 0, 1, 5, 0, 1, 1, 6);
    n_vec++; if (protocol_err_o !== 1'b1 || err_id_o !== 4'd5) begin n_err++; $display("FAIL err_priority: got err=%b id=%0d want 1 5", protocol_err_o, err_id_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    iss(1'b0);
    cmt(0, 1'b0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    n_vec++; if (issue_id_o !== 4'd0 || outstanding_cnt_o !== 3'd1) begin n_err++; $display("FAIL b2b_realloc: got id=%0d cnt=%0d want 0 1", issue_id_o, outstanding_cnt_o); end
    cmt(1, 1'b0);
    n_vec++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL b2b_got_id1: got err=%b want 0", protocol_err_o); end
    do_reset();
    iss(1'b0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    n_vec++; if (protocol_err_o !== 1'b1 || outstanding_cnt_o !== 3'd1) begin n_err++; $display("FAIL same_id_commit_result: got err=%b cnt=%0d want 1 1", protocol_err_o, outstanding_cnt_o); end
    res(0);
    n_vec++; if (outstanding_cnt_o !== 3'd0) begin n_err++; $display("FAIL same_id_commit_applied: got %0d want 0", outstanding_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) iss(1'b1);
    cmt(0, 1'b0);
    do_reset();
    n_vec++; if (outstanding_cnt_o !== 3'd0 || all_idle_o !== 1'b1 || issue_id_o !== 4'd0) begin n_err++; $display("FAIL midrst_state: got cnt=%0d idle=%b id=%0d want 0 1 0", outstanding_cnt_o, all_idle_o, issue_id_o); end
    n_vec++; if (protocol_err_o !== 1'b0 || wb_pending_o !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got err=%b wbp=%b want 0 0", protocol_err_o, wb_pending_o); end
    res(0);
    n_vec++; if (protocol_err_o !== 1'b1 || err_id_o !== 4'd0) begin n_err++; $display("FAIL midrst_stale_result: got err=%b id=%0d want 1 0", protocol_err_o, err_id_o); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 30 == 0) do_reset();
      step($urandom % 2, ($urandom % 4) != 0, ($urandom % 4) != 0, $urandom % 2,
           ($urandom % 3) == 0, $urandom_range(0, 5), ($urandom % 3) == 0,
           ($urandom % 3) == 0, ($urandom % 4) != 0, $urandom_range(0, 5));
      n_vec++; if (outstanding_cnt_o !== CW'(m_cnt())) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", k, outstanding_cnt_o, m_cnt()); end
      n_vec++; if (issue_id_o !== W'(m_issue_id())) begin n_err++; $display("FAIL rnd_id@%0d: got %0d want %0d", k, issue_id_o, m_issue_id()); end
      n_vec++; if (issue_allowed_o !== m_allowed()) begin n_err++; $display("FAIL rnd_allowed@%0d: got %b want %b", k, issue_allowed_o, m_allowed()); end
      n_vec++; if (all_idle_o !== (m_cnt() == 0)) begin n_err++; $display("FAIL rnd_idle@%0d: got %b want %b", k, all_idle_o, m_cnt() == 0); end
      n_vec++; if (wb_pending_o !== m_wbp()) begin n_err++; $display("FAIL rnd_wbp@%0d: got %b want %b", k, wb_pending_o, m_wbp()); end
      n_vec++; if (protocol_err_o !== m_err || err_id_o !== W'(m_err_id)) begin n_err++; $display("FAIL rnd_err@%0d: got %b/%0d want %b/%0d", k, protocol_err_o, err_id_o, m_err, m_err_id); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_writeback();
    test_kill();
    test_simultaneous();
    test_early_result();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
